barrel_shift_sequencer: RTL and testbench

Sequential front-end for the 4-bit combinational barrel shifter. Accepts operand words over a valid/ready handshake and drives the shifter's data/shift-amount inputs from registers. Samples the shifter output and presents each result downstream over a valid/ready handshake. Optional sweep mode applies every shift amount 0..2^AMT_W-1 to one operand and emits one result per amount.

---
 rtl/barrel_shift_sequencer.sv | 119 +++++++++++
 tb/tb_barrel_shift_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/barrel_shift_sequencer.sv
// barrel_shift_sequencer
//
// Sequential front-end for a combinational barrel shifter. Accepts one
// operand request at a time over a valid/ready handshake, drives the
// shifter inputs from registers, samples the shifter's combinational return
// one cycle later and offers the result downstream over a valid/ready
// handshake. In sweep mode the operand is shifted by every amount from 0 to
// 2^AMT_W-1 in turn, and one result is emitted per amount.
//
// State table:
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   S_IDLE    | waiting for a request; in_ready=1, shifter inputs held
//   S_APPLY   | shifter inputs stable for one full cycle; result sampled
//             | at the closing edge
//   S_PRESENT | result offered downstream; held until out_ready
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   in_valid/ready  operand handshake
//   in_data         operand word
//   in_amt          shift amount (ignored when in_sweep=1)
//   in_sweep        1 = sweep all amounts starting at 0
//   sh_data_in      registered operand to the shifter
//   sh_shift_amt    registered shift amount to the shifter
//   sh_data_out     shifter output (combinational return)
//   out_valid/ready result handshake
//   out_data        captured shifter result
//   out_amt         amount that produced out_data
//   out_last        final result of the current request

module barrel_shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_sweep,
    output logic [WIDTH-1:0] sh_data_in,
    output logic [AMT_W-1:0] sh_shift_amt,
    input  logic [WIDTH-1:0] sh_data_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [AMT_W-1:0] out_amt,
    output logic             out_last
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_APPLY   = 2'd1,
        S_PRESENT = 2'd2
    } state_t;

    state_t state;
    logic   sweep;

    // in_ready and out_valid are registered alongside the state so they are
    // glitch-free and can never be high together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sweep        <= 1'b0;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            out_last     <= 1'b0;
            out_data     <= '0;
            out_amt      <= '0;
            sh_data_in   <= '0;
            sh_shift_amt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sh_data_in   <= in_data;
                        sh_shift_amt <= in_sweep ? '0 : in_amt;
                        sweep        <= in_sweep;
                        in_ready     <= 1'b0;
                        state        <= S_APPLY;
                    end
                end

                S_APPLY: begin
                    out_data  <= sh_data_out;
                    out_amt   <= sh_shift_amt;
                    // A sweep ends at the all-ones amount, so the increment
                    // below never wraps.
                    out_last  <= !sweep || (&sh_shift_amt);
                    out_valid <= 1'b1;
                    state     <= S_PRESENT;
                end

                S_PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            in_ready <= 1'b1;
                            state    <= S_IDLE;
                        end else begin
                            sh_shift_amt <= sh_shift_amt + 1'b1;
                            state        <= S_APPLY;
                        end
                    end
                end

                default: begin
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_barrel_shift_sequencer.sv
// Testbench for barrel_shift_sequencer. A rotate-left model stands in for
// the combinational shifter. Single operations come from a vector table;
// sweeps, backpressure, busy-ignore and mid-sweep reset are hand sequences.

module tb_barrel_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic [1:0] in_amt = '0;
    logic       in_sweep = 1'b0;
    logic [3:0] sh_data_in;
    logic [1:0] sh_shift_amt;
    logic [3:0] sh_data_out;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_data;
    logic [1:0] out_amt;
    logic       out_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    function automatic logic [3:0] rotl(input logic [3:0] d, input logic [1:0] a);
        logic [7:0] t;
        t = {d, d} << a;
        return t[7:4];
    endfunction

    assign sh_data_out = rotl(sh_data_in, sh_shift_amt);

    barrel_shift_sequencer #(.WIDTH(4), .AMT_W(2)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_amt       (in_amt),
        .in_sweep     (in_sweep),
        .sh_data_in   (sh_data_in),
        .sh_shift_amt (sh_shift_amt),
        .sh_data_out  (sh_data_out),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_amt      (out_amt),
        .out_last     (out_last)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " in_ready"}, {7'd0, in_ready}, 8'd1);
        chk({tag, " out_valid"}, {7'd0, out_valid}, 8'd0);
    endtask

    task automatic chk_result(input string tag, input logic [3:0] d, input logic [1:0] a,
                              input logic last);
        chk({tag, " out_valid"}, {7'd0, out_valid}, 8'd1);
        chk({tag, " in_ready"}, {7'd0, in_ready}, 8'd0);
        chk({tag, " out_data"}, {4'd0, out_data}, {4'd0, d});
        chk({tag, " out_amt"}, {6'd0, out_amt}, {6'd0, a});
        chk({tag, " out_last"}, {7'd0, out_last}, {7'd0, last});
    endtask

    // Present a request just before edge N; returns after edge N with
    // in_valid dropped.
    task automatic request(input logic [3:0] d, input logic [1:0] a, input logic sw);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = a;
        in_sweep = sw;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic single_op(input string tag, input logic [3:0] d, input logic [1:0] a,
                             input logic [3:0] exp);
        out_ready = 1'b1;
        request(d, a, 1'b0);
        @(negedge clk);  // N+1
        chk({tag, " apply out_valid"}, {7'd0, out_valid}, 8'd0);
        chk({tag, " apply in_ready"}, {7'd0, in_ready}, 8'd0);
        @(negedge clk);  // N+2
        chk_result(tag, exp, a, 1'b1);
        @(negedge clk);  // N+3
        chk_idle({tag, " done"});
    endtask

    typedef struct {
        logic [3:0] data;
        logic [1:0] amt;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs[5];
    logic [3:0] sweep_exp[4];

    initial begin
        vecs[0] = '{4'b0001, 2'd2, 4'b0100};
        vecs[1] = '{4'b1001, 2'd1, 4'b0011};
        vecs[2] = '{4'b1010, 2'd3, 4'b0101};
        vecs[3] = '{4'b0110, 2'd0, 4'b0110};
        vecs[4] = '{4'b1110, 2'd2, 4'b1011};

        // Reset and idle
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle("reset");
        chk("reset out_data", {4'd0, out_data}, 8'd0);
        chk("reset out_amt", {6'd0, out_amt}, 8'd0);
        chk("reset out_last", {7'd0, out_last}, 8'd0);
        chk("reset sh_data_in", {4'd0, sh_data_in}, 8'd0);
        chk("reset sh_shift_amt", {6'd0, sh_shift_amt}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk_idle("idle");
        chk("idle sh_data_in", {4'd0, sh_data_in}, 8'd0);

        // Single operations from the table
        for (int i = 0; i < 5; i++)
            single_op($sformatf("single%0d", i), vecs[i].data, vecs[i].amt, vecs[i].exp);

        // Full sweep of 0001, out_ready held high
        sweep_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        request(4'b0001, 2'd3, 1'b1);  // in_amt ignored in sweep
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("sweep%0d apply out_valid", k), {7'd0, out_valid}, 8'd0);
            @(negedge clk);
            chk_result($sformatf("sweep%0d", k), sweep_exp[k], 2'(k), k == 3);
        end
        @(negedge clk);
        chk_idle("sweep done");
        chk("sweep hold sh_data_in", {4'd0, sh_data_in}, 8'b0000_0001);
        chk("sweep hold sh_shift_amt", {6'd0, sh_shift_amt}, 8'd3);

        // Backpressure on the second result of a sweep of 1001
        request(4'b1001, 2'd0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        chk_result("bp0", 4'b1001, 2'd0, 1'b0);
        @(negedge clk);  // APPLY for amount 1
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk_result($sformatf("bp1 stall%0d", c), 4'b0011, 2'd1, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp2 apply out_valid", {7'd0, out_valid}, 8'd0);
        @(negedge clk);
        chk_result("bp2", 4'b0110, 2'd2, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_result("bp3", 4'b1100, 2'd3, 1'b1);
        @(negedge clk);
        chk_idle("bp done");

        // in_valid held high with changing data during a sweep
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'b0001;
        in_sweep = 1'b1;
        @(posedge clk);  // edge N
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_data  = 4'(4'b1111 - k);
            in_amt   = 2'(k);
            in_sweep = 1'b0;
            @(negedge clk);
            chk_result($sformatf("busy%0d", k), sweep_exp[k], 2'(k), k == 3);
            if (k == 3) begin
                in_data = 4'b0011;
                in_amt  = 2'd1;
            end
        end
        @(negedge clk);  // N+9
        chk_idle("busy return");
        chk("busy hold sh_data_in", {4'd0, sh_data_in}, 8'b0000_0001);
        @(posedge clk);  // accept queued word
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("busy next sh_data_in", {4'd0, sh_data_in}, 8'b0000_0011);
        chk("busy next sh_shift_amt", {6'd0, sh_shift_amt}, 8'd1);
        @(negedge clk);
        chk_result("busy next", 4'b0110, 2'd1, 1'b1);
        @(negedge clk);
        chk_idle("busy next done");

        // Reset asserted mid-sweep after the second result
        request(4'b0001, 2'd0, 1'b1);
        repeat (4) @(negedge clk);
        chk_result("rst mid", 4'b0010, 2'd1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("rst async");
        chk("rst async out_data", {4'd0, out_data}, 8'd0);
        chk("rst async sh_shift_amt", {6'd0, sh_shift_amt}, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_idle("rst release");
        single_op("after rst", 4'b0001, 2'd2, 4'b0100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
